// File: rtl/sd_ctrl_pkg.sv
// Shared types and default constants for the SD share controller.
package sd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FIN,
    DONE,
    ERR
  } sd_state_t;

  localparam int unsigned XS_LEN_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 1000;

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sd_rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    winner
);

  always_comb begin
    logic [PW-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sd_share_ctrl.sv
// Time-shares one SD unit among N_REQ requesters: round-robin grant, xs strobe,
// wait for fin with timeout, then a done/to_err pulse to the owner.
module sd_share_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned XS_LEN  = XS_LEN_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] to_err,
  output logic             busy,
  output logic             sd_xs,
  input  logic             sd_fin
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned XW = $clog2(XS_LEN + 1);

  sd_state_t        state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [XW-1:0]    xcnt_q, xcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [N_REQ-1:0] grant_d, done_d, to_err_d;
  logic             busy_d, xs_d;

  logic             pick_valid;
  logic [PW-1:0]    pick_w;

  sd_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      xcnt_q  <= '0;
      tcnt_q  <= '0;
      grant   <= '0;
      done    <= '0;
      to_err  <= '0;
      busy    <= 1'b0;
      sd_xs   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      xcnt_q  <= xcnt_d;
      tcnt_q  <= tcnt_d;
      grant   <= grant_d;
      done    <= done_d;
      to_err  <= to_err_d;
      busy    <= busy_d;
      sd_xs   <= xs_d;
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    xcnt_d   = xcnt_q;
    tcnt_d   = tcnt_q;
    grant_d  = grant;
    done_d   = '0;
    to_err_d = '0;
    busy_d   = busy;
    xs_d     = sd_xs;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d         = START;
          win_d           = pick_w;
          grant_d         = '0;
          grant_d[pick_w] = 1'b1;
          xs_d            = 1'b1;
          busy_d          = 1'b1;
          xcnt_d          = '0;
        end
      end
      START: begin
        if (xcnt_q == XW'(XS_LEN - 1)) begin
          state_d = WAIT_FIN;
          xs_d    = 1'b0;
          tcnt_d  = '0;
        end else begin
          xcnt_d = xcnt_q + 1'b1;
        end
      end
      WAIT_FIN: begin
        tcnt_d = tcnt_q + 1'b1;
        // fin takes priority over a timeout in the same cycle
        if (sd_fin) begin
          state_d = DONE;
          done_d  = grant;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = ERR;
          to_err_d = grant;
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        xs_d    = 1'b0;
      end
    endcase
  end

endmodule
